// File: rtl/echo_pulse_meter.sv
// Echo pulse width meter: times an ultrasonic echo in prescaled ticks after a start pulse.
// Optional ECHO_GLITCH_FILTER_EN inserts a 3-sample glitch filter after the synchronizer.
module echo_pulse_meter #(
    parameter int TICK_DIV  = 50,
    parameter int CNT_WIDTH = 16,
    parameter int TIMEOUT   = 38000,
    parameter bit POLARITY  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 echo,
    output logic [CNT_WIDTH-1:0] width,
    output logic                 valid,
    output logic                 busy,
    output logic                 timeout
);

    localparam int                   TICK_W    = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(TIMEOUT);
    localparam logic                 RAW_IDLE  = ~POLARITY;

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, DONE} state_t;

    state_t                 state;
    logic [TICK_W-1:0]      tick, tick_nxt;
    logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
    logic                   sync1, sync2, cur, lvl, prev;
    logic                   rise, fall;

    // Raw echo is held at its inactive level in reset so no edge appears on release.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= RAW_IDLE;
            sync2 <= RAW_IDLE;
        end else begin
            sync1 <= echo;
            sync2 <= sync1;
        end
    end

    assign cur = sync2 ~^ POLARITY;

`ifdef ECHO_GLITCH_FILTER_EN
    logic hist1, hist2, filt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist1  <= 1'b0;
            hist2  <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            hist1  <= cur;
            hist2  <= hist1;
            filt_q <= lvl;
        end
    end

    // Level follows cur only once three consecutive samples agree; adds two cycles to each edge.
    assign lvl = (cur == hist1 && hist1 == hist2) ? cur : filt_q;
`else
    assign lvl = cur;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= 1'b0;
        else     prev <= lvl;
    end

    assign rise = lvl & ~prev;
    assign fall = ~lvl & prev;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tick_nxt = tick + TICK_W'(1);
        cnt_nxt  = cnt;
        if (tick == TICK_LAST) begin
            tick_nxt = '0;
            cnt_nxt  = cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tick    <= '0;
            cnt     <= '0;
            width   <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= WAIT_EDGE;
                        tick  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                WAIT_EDGE: begin
                    if (rise) begin
                        // The detection cycle is already the first active cycle.
                        state <= MEASURE;
                        tick  <= TICK_W'(1);
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state   <= DONE;
                        width   <= '0;
                        timeout <= 1'b1;
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        tick <= tick_nxt;
                        cnt  <= cnt_nxt;
                    end
                end
                MEASURE: begin
                    if (fall) begin
                        state   <= DONE;
                        width   <= cnt;
                        timeout <= 1'b0;
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        state   <= DONE;
                        width   <= CNT_MAX;
                        timeout <= 1'b1;
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        tick <= tick_nxt;
                        cnt  <= cnt_nxt;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_echo_pulse_meter.sv
// Self-checking bench for echo_pulse_meter: expected results are queued at arm time
// and compared when valid strobes. Honours ECHO_GLITCH_FILTER_EN for the glitch case.
module tb_echo_pulse_meter;

    localparam int TICK_DIV  = 4;
    localparam int CNT_WIDTH = 8;
    localparam int TIMEOUT   = 10;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 echo = 1'b0;
    logic [CNT_WIDTH-1:0] width;
    logic                 valid, busy, timeout;

    typedef struct {
        int unsigned w;
        bit          t;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    echo_pulse_meter #(
        .TICK_DIV (TICK_DIV),
        .CNT_WIDTH(CNT_WIDTH),
        .TIMEOUT  (TIMEOUT),
        .POLARITY (1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .echo   (echo),
        .width  (width),
        .valid  (valid),
        .busy   (busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Scoreboard: each valid strobe consumes one queued expectation.
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_width", 32'(width), e.w);
                check("sb_timeout", 32'(timeout), 32'(e.t));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_result(input int unsigned w, input bit t);
        exp_t e;
        e.w = w;
        e.t = t;
        exp_q.push_back(e);
    endtask

    task automatic arm();
        start = 1'b1;
        cycles(1);
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int max, output int k);
        k = 0;
        for (int i = 1; i <= max; i++) begin
            cycles(1);
            if (valid) begin
                k = i;
                break;
            end
        end
        check({tag, "_arrived"}, 32'(k != 0), 32'd1);
    endtask

    initial begin
        int k;

        #1;
        check("rst_width", 32'(width), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        cycles(3);
        rst = 1'b0;
        cycles(2);

        // 22-cycle pulse -> floor(22/4) = 5
        expect_result(5, 1'b0);
        arm();
        check("t1_busy", 32'(busy), 32'd1);
        cycles(2);
        echo = 1'b1;
        cycles(22);
        echo = 1'b0;
        wait_valid("t1", 10, k);
        check("t1_valid_edge", 32'(k), 32'd3);
        check("t1_busy_done", 32'(busy), 32'd0);
        cycles(1);
        check("t1_valid_once", 32'(valid), 32'd0);
        cycles(3);

        // No echo: timeout after about TIMEOUT*TICK_DIV cycles
        expect_result(0, 1'b1);
        arm();
        wait_valid("t2", 60, k);
        check("t2_timeout_window", 32'(k >= 40 && k <= 41), 32'd1);
        check("t2_busy_done", 32'(busy), 32'd0);
        cycles(3);

        // 60-cycle pulse saturates at TIMEOUT; 2 sync edges + detection edge + 40 cycles
        expect_result(TIMEOUT, 1'b1);
        arm();
        cycles(1);
        echo = 1'b1;
        wait_valid("t3", 60, k);
        check("t3_valid_edge", 32'(k), 32'd43);
        cycles(60 - 43);
        echo = 1'b0;
        cycles(10);
        check("t3_hold_width", 32'(width), 32'(TIMEOUT));
        check("t3_hold_timeout", 32'(timeout), 32'd1);

        // Reset mid-measurement clears outputs at once and drops the measurement
        arm();
        cycles(1);
        echo = 1'b1;
        cycles(10);
        rst = 1'b1;
        #1;
        check("t5_rst_width", 32'(width), 32'd0);
        check("t5_rst_timeout", 32'(timeout), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_valid", 32'(valid), 32'd0);
        echo = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(15);
        expect_result(4, 1'b0);
        arm();
        cycles(1);
        echo = 1'b1;
        cycles(16);
        echo = 1'b0;
        wait_valid("t5", 10, k);
        check("t5_valid_edge", 32'(k), 32'd3);
        cycles(3);

        // Echo already active at arm; ignored start pulses while busy
        echo = 1'b1;
        cycles(4);
        expect_result(3, 1'b0);
        arm();
        check("t4_busy", 32'(busy), 32'd1);
        cycles(3);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(4);
        echo = 1'b0;
        cycles(8);
        echo = 1'b1;
        cycles(5);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(6);
        echo = 1'b0;
        wait_valid("t4", 10, k);

        // Re-arm one cycle after valid, then a 2-cycle glitch
        cycles(1);
`ifdef ECHO_GLITCH_FILTER_EN
        expect_result(0, 1'b1);
`else
        expect_result(0, 1'b0);
`endif
        arm();
        check("t6_rearm_busy", 32'(busy), 32'd1);
        cycles(1);
        echo = 1'b1;
        cycles(2);
        echo = 1'b0;
        wait_valid("t6", 60, k);
        cycles(5);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
